// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer: feeds one signed 8x8 operand pair per transaction onto the
// Booth multiplier's shared select/multIn bus, waits out its pipeline, and returns the product.
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake carrying in_a (multiplicand) and in_b (multiplier)
//   mult_select/mult_in   multiplier load bus (0 = multiplicand, 1 = multiplier)
//   mult_product          multiplier's registered product
//   out_valid/out_ready   result handshake carrying out_product
//   busy                  high outside IDLE
//   txn_count             completed output handshakes, wrapping
module booth_operand_sequencer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        mult_select,
    output logic [7:0]  mult_in,
    input  logic [15:0] mult_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        busy,
    output logic [15:0] txn_count
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, CAPTURE, DONE} state_t;
    state_t     state, state_next;
    logic [7:0] a_q, b_q;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Outside LOAD_A the bus keeps rewriting the multiplier register with b_q,
    // so the multiplicand is only ever loaded in LOAD_A.
    always_comb begin
        state_next  = state;
        in_ready    = state == IDLE;
        busy        = state != IDLE;
        mult_select = state != LOAD_A;
        mult_in     = state == LOAD_A ? a_q : b_q;
        case (state)
            IDLE:    state_next = in_valid ? LOAD_A : IDLE;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = WAIT;
            WAIT:    state_next = wait_cnt == 4'd1 ? CAPTURE : WAIT;
            CAPTURE: state_next = DONE;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            wait_cnt    <= '0;
            out_product <= '0;
            out_valid   <= 1'b0;
            txn_count   <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (state == LOAD_B)
                wait_cnt <= 4'(WAIT_CYCLES);
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == CAPTURE) begin
                out_product <= mult_product;
                out_valid   <= 1'b1;
            end
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
                txn_count <= txn_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// tb_booth_operand_sequencer: scoreboard bench for two sequencers (WAIT_CYCLES 1 and 3), each driving a behavioural multiplier.
module tb_booth_operand_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid[2], in_ready[2], mult_select[2], out_valid[2], out_ready[2], busy[2];
    logic [7:0]  in_a[2], in_b[2], mult_in[2];
    logic [15:0] mult_product[2], out_product[2], txn_count[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] sb[2][$];
    logic        inflight[2];
    int          acc_m[2], rise_m[2], acc_dut[2], hs_dut[2];
    logic [7:0]  a_m[2], b_m[2];
    logic [15:0] txn_m[2];
    logic signed [7:0] mcand[2], mplier[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_operand_sequencer #(.WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .mult_select(mult_select[0]), .mult_in(mult_in[0]),
        .mult_product(mult_product[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_product(out_product[0]), .busy(busy[0]), .txn_count(txn_count[0])
    );

    booth_operand_sequencer #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .mult_select(mult_select[1]), .mult_in(mult_in[1]),
        .mult_product(mult_product[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_product(out_product[1]), .busy(busy[1]), .txn_count(txn_count[1])
    );

    function automatic int wc(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Pin-limited multiplier: select 0 loads multiplicand, 1 loads multiplier, product registered.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!mult_select[k])
                mcand[k] <= mult_in[k];
            else
                mplier[k] <= mult_in[k];
            mult_product[k] <= model_product(mcand[k], mplier[k]);
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int k);
        checks++;
        errors++;
        $display("FAIL %s u%0d cycle %0d: timed out", nm, k, cyc);
    endtask

    // Protocol model and scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                chk("rst_out_valid", k, out_valid[k], 0);
                chk("rst_in_ready", k, in_ready[k], 1);
                chk("rst_busy", k, busy[k], 0);
                chk("rst_mult_select", k, mult_select[k], 1);
                chk("rst_mult_in", k, mult_in[k], 0);
                chk("rst_out_product", k, out_product[k], 0);
                chk("rst_txn_count", k, txn_count[k], 0);
                inflight[k] = 1'b0;
                b_m[k] = 8'd0;
                txn_m[k] = 16'd0;
                sb[k].delete();
            end else begin
                chk("in_ready", k, in_ready[k], !inflight[k]);
                chk("busy", k, busy[k], inflight[k]);
                chk("out_valid", k, out_valid[k], inflight[k] && cyc >= rise_m[k]);
                chk("mult_select", k, mult_select[k], !(inflight[k] && cyc == acc_m[k]));
                chk("mult_in", k, mult_in[k], (inflight[k] && cyc == acc_m[k]) ? a_m[k] : b_m[k]);
                chk("txn_count", k, txn_count[k], txn_m[k]);
                if (out_valid[k] && out_ready[k]) begin
                    hs_dut[k] = cyc + 1;
                    if (sb[k].size() == 0)
                        timeout("unexpected_output", k);
                    else
                        chk("out_product", k, out_product[k], sb[k].pop_front());
                end else if (out_valid[k] && sb[k].size() != 0) begin
                    chk("held_product", k, out_product[k], sb[k][0]);
                end
                if (in_valid[k] && in_ready[k])
                    acc_dut[k] = cyc + 1;
                if (inflight[k] && cyc >= rise_m[k] && out_ready[k]) begin
                    inflight[k] = 1'b0;
                    txn_m[k] = txn_m[k] + 16'd1;
                end else if (!inflight[k] && in_valid[k]) begin
                    inflight[k] = 1'b1;
                    acc_m[k] = cyc + 1;
                    rise_m[k] = cyc + 1 + 3 + wc(k);
                    a_m[k] = in_a[k];
                    b_m[k] = in_b[k];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        in_a[k] = a;
        in_b[k] = b;
        in_valid[k] = 1'b1;
        sb[k].push_back(model_product(a, b));
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready[k];
        end
        tick(1);
        in_valid[k] = 1'b0;
        if (!ok)
            timeout("accept", k);
    endtask

    task automatic drain(input int k);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = sb[k].size() == 0;
        end
        tick(1);
        if (!ok)
            timeout("drain", k);
    endtask

    task automatic wait_ov(input int k);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid[k];
        end
        if (!ok)
            timeout("out_valid", k);
    endtask

    task automatic rand_run(input int k, input int n);
        bit done = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    tick($urandom_range(0, 2));
                    send(k, 8'($urandom), 8'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    tick(1);
                    out_ready[k] = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready[k] = 1'b1;
        drain(k);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            in_a[k] = 8'd0;
            in_b[k] = 8'd0;
            out_ready[k] = 1'b1;
            inflight[k] = 1'b0;
            acc_m[k] = -10;
            rise_m[k] = 0;
            acc_dut[k] = 0;
            hs_dut[k] = 0;
            a_m[k] = 8'd0;
            b_m[k] = 8'd0;
            txn_m[k] = 16'd0;
            mcand[k] = 8'sd0;
            mplier[k] = 8'sd0;
        end
        tick(3);
        reset = 1'b0;
        tick(1);

        send(0, 8'd7, 8'hFD);
        send(0, 8'h80, 8'h80);
        chk("b2b_accept_edge", 0, acc_dut[0], hs_dut[0] + 1);
        send(0, 8'h80, 8'h7F);
        send(0, 8'h00, 8'hFF);
        drain(0);

        out_ready[0] = 1'b0;
        send(0, 8'd11, 8'd13);
        wait_ov(0);
        tick(1);
        in_a[0] = 8'd9;
        in_b[0] = 8'hF7;
        in_valid[0] = 1'b1;
        sb[0].push_back(model_product(8'd9, 8'hF7));
        tick(5);
        out_ready[0] = 1'b1;
        wait_ov(0);
        begin
            bit ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready[0];
            end
            tick(1);
            in_valid[0] = 1'b0;
            if (!ok)
                timeout("accept_after_hold", 0);
        end
        chk("accept_after_hold_edge", 0, acc_dut[0], hs_dut[0] + 1);
        drain(0);

        in_a[0] = 8'd33;
        in_b[0] = 8'd44;
        in_valid[0] = 1'b1;
        tick(1);
        in_valid[0] = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        chk("txn_after_reset", 0, txn_count[0], 0);
        send(0, 8'd5, 8'd5);
        drain(0);

        send(1, 8'd100, 8'h9C);
        drain(1);

        rand_run(0, 30);
        rand_run(1, 10);

        force u0.txn_count = 16'hFFFF;
        txn_m[0] = 16'hFFFF;
        #1;
        release u0.txn_count;
        tick(1);
        send(0, 8'h81, 8'h03);
        drain(0);
        chk("txn_wrap", 0, txn_count[0], 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_operand_sequencer.md
# booth_operand_sequencer

Upstream front-end for the pin-limited 8x8 signed Booth multiplier, which loads multiplicand and multiplier one byte at a time over a shared `select`/`multIn` bus. The block accepts one operand pair per valid/ready transaction and time-multiplexes the pair onto that bus. It waits out the multiplier's pipeline, then captures the registered 16-bit product and presents it downstream with its own valid/ready handshake. The multiplier itself is instantiated by the parent; this block owns only the sequencing.

## Interface
- `WAIT_CYCLES`, default 1: number of clock edges spent in WAIT after the multiplier operand is loaded. Legal range 1..15. Value 1 matches the multiplier's single output register.
- `clk`  in  1  rising-edge clock, shared with the multiplier.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair.
- `in_a`  in  8  signed multiplicand.
- `in_b`  in  8  signed multiplier.
- `mult_select`  out  1  drives the multiplier's `select`: 0 loads the multiplicand, 1 loads the multiplier.
- `mult_in`  out  8  drives the multiplier's `multIn`.
- `mult_product`  in  16  the multiplier's registered `product`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `out_product`  out  16  signed product `in_a*in_b`.
- `busy`  out  1  high whenever the state is not IDLE.
- `txn_count`  out  16  count of completed output handshakes; wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT, CAPTURE, DONE.
- The FSM advances on every edge; the only holds are IDLE (waiting for input) and DONE (waiting for output).
- IDLE
  - `in_ready`=1.
  - On `in_valid`: latch `in_a` into `a_q` and `in_b` into `b_q`, go to LOAD_A.
- LOAD_A: `mult_select`=0, `mult_in`=`a_q`. Next state LOAD_B.
- LOAD_B: `mult_select`=1, `mult_in`=`b_q`. Next state WAIT; load the wait counter with `WAIT_CYCLES`.
- WAIT: decrement the counter each edge. Go to CAPTURE on the edge where the counter is 1.
- CAPTURE: at the edge, `out_product` <= `mult_product` and `out_valid` <= 1. Next state DONE.
- DONE
  - Hold `out_valid`=1 and `out_product` stable until `out_ready`.
  - On the handshake edge: `out_valid` <= 0, `txn_count` += 1, go to IDLE.
- `mult_select`/`mult_in` drive rule:
  - In every state except LOAD_A: `mult_select`=1 and `mult_in`=`b_q`.
  - The multiplier register is therefore only ever rewritten with its current value, and the multiplicand is never disturbed outside LOAD_A.
  - Both outputs are registered or decoded from registered state only, with no combinational path from `in_*`.
- `in_ready` = (state==IDLE), a combinational decode of the state register.
  - A new pair is accepted only after the previous result is consumed; there is no overlap.
- Arithmetic: none inside the block. `out_product` is exactly `mult_product` captured in CAPTURE, two's complement 16-bit.
- Inputs are don't-care outside their handshake states: `in_*` outside IDLE, `out_ready` outside DONE.
- `in_valid` deasserting before acceptance is legal; nothing is latched.
- Reset (asynchronous, any state, including mid-operation):
  - State -> IDLE.
  - `a_q`, `b_q`, wait counter, `out_product`, `txn_count` -> 0.
  - `out_valid`=0, `busy`=0, `in_ready`=1, `mult_select`=1, `mult_in`=0.
  - Any in-flight pair is discarded with no output.

## Timing
- Acceptance edge E0.
- `mult_select`=0 during the cycle after E0; the multiplier latches the multiplicand at E1.
- `mult_select`=1 with `b_q` driven; the multiplier latches the multiplier operand at E2.
- The multiplier registers the product at E3.
- `out_valid` rises after edge E(3+`WAIT_CYCLES`): E4 for the default.
- With `out_ready` tied high:
  - the output handshake occurs at E(4+`WAIT_CYCLES`);
  - IDLE is re-entered at that edge and the next pair can be accepted at the following edge;
  - throughput is one pair per `WAIT_CYCLES`+5 cycles (6 cycles for the default).
- `busy` is high from E0 through the output handshake edge.

## Test plan
- Normal pair: `in_a`=7, `in_b`=-3, `out_ready`=1 -> `out_valid` high exactly 4 edges after acceptance with `out_product`=0xFFEB; `txn_count` 0->1.
- Corner values:
  - -128 x -128 -> 0x4000.
  - -128 x 127 -> 0xC080.
  - 0 x -1 -> 0x0000.
- Bus check for each pair: `mult_select`=0 for exactly one cycle carrying `in_a`, then stays 1 carrying `in_b`.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises.
  - `out_product` stays stable, `in_ready` stays 0, and `in_valid` offered meanwhile is not accepted.
  - After release, the next pair is accepted one edge after the handshake.
- Reset mid-operation:
  - Assert `reset` during WAIT -> `out_valid` never asserts for that pair and `txn_count` stays 0.
  - After release, a pair 5 x 5 -> 0x0019.
- `WAIT_CYCLES`=3: pair 100 x -100 -> `out_valid` 6 edges after acceptance with 0xD8F0.
- Counter wrap: force `txn_count`=0xFFFF via 65535 transactions (or a hierarchical preload), complete one more handshake -> 0x0000.
